// File: rtl/d_mem_lsu.sv
// d_mem_lsu: MEM-stage load/store initiator for the byte-addressed data memory.
// Accepts one request per handshake, performs a single memory access cycle,
// then emits a one-cycle response carrying the extended load data.
// Optional build macro: LSU_MISALIGN_TRAP_EN rejects misaligned H/HU/W accesses.
//
// state  | meaning
// IDLE   | ready for a request; all memory outputs low
// ACCESS | memory read or write in flight; load data captured at end of cycle
// RESP   | resp_valid pulse; memory outputs low
module d_mem_lsu #(
    parameter int ADDR_W   = 32,
    parameter int MEM_SIZE = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              Mem_r,
    output logic              Mem_w,
    output logic [ADDR_W-1:0] Mem_Addr,
    output logic [31:0]       Mem_W_Data,
    output logic [3:0]        Mem_W_Strb,
    input  logic [31:0]       Mem_R_Data
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t     state;
    logic       we_q;
    logic [2:0] funct3_q;
    logic       req_err;

    // The last-byte address is formed one bit wider so that an access near the
    // top of the address space cannot wrap around and slip past the bound.
    function automatic logic calc_err(input logic we, input logic [2:0] f3,
                                      input logic [ADDR_W-1:0] addr);
        logic [ADDR_W:0] last;
        logic            bad;
        bad  = 1'b0;
        last = {1'b0, addr};
        case (f3)
            3'b000, 3'b100: last = {1'b0, addr};
            3'b001, 3'b101: last = {1'b0, addr} + (ADDR_W+1)'(1);
            3'b010:         last = {1'b0, addr} + (ADDR_W+1)'(3);
            default:        bad  = 1'b1;
        endcase
        if (we && f3[2]) bad = 1'b1;
        if (last >= (ADDR_W+1)'(MEM_SIZE)) bad = 1'b1;
`ifdef LSU_MISALIGN_TRAP_EN
        if ((f3[1:0] == 2'b01 && addr[0]) || (f3 == 3'b010 && addr[1:0] != 2'b00))
            bad = 1'b1;
`endif
        return bad;
    endfunction

    function automatic logic [3:0] calc_strb(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 4'b0001;
            2'b01:   return 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] extend(input logic [2:0] f3, input logic [31:0] d);
        case (f3)
            3'b000:  return {{24{d[7]}}, d[7:0]};
            3'b100:  return {24'h0, d[7:0]};
            3'b001:  return {{16{d[15]}}, d[15:0]};
            3'b101:  return {16'h0, d[15:0]};
            default: return d;
        endcase
    endfunction

    // Request rejection decision, evaluated on the incoming request in IDLE.
    always_comb begin
        req_err = calc_err(req_we, req_funct3, req_addr);
    end

    // Sequencer with all outputs registered; reset drops memory enables at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            we_q       <= 1'b0;
            funct3_q   <= 3'b000;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= 32'h0;
            resp_err   <= 1'b0;
            Mem_r      <= 1'b0;
            Mem_w      <= 1'b0;
            Mem_Addr   <= '0;
            Mem_W_Data <= 32'h0;
            Mem_W_Strb <= 4'b0000;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        we_q      <= req_we;
                        funct3_q  <= req_funct3;
                        req_ready <= 1'b0;
                        if (req_err) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                        end else begin
                            state      <= ACCESS;
                            Mem_r      <= ~req_we;
                            Mem_w      <= req_we;
                            Mem_Addr   <= req_addr;
                            Mem_W_Data <= req_wdata;
                            Mem_W_Strb <= req_we ? calc_strb(req_funct3) : 4'b0000;
                        end
                    end
                end
                ACCESS: begin
                    if (!we_q) resp_rdata <= extend(funct3_q, Mem_R_Data);
                    state      <= RESP;
                    resp_valid <= 1'b1;
                    resp_err   <= 1'b0;
                    Mem_r      <= 1'b0;
                    Mem_w      <= 1'b0;
                    Mem_Addr   <= '0;
                    Mem_W_Data <= 32'h0;
                    Mem_W_Strb <= 4'b0000;
                end
                default: begin
                    state      <= IDLE;
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    req_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_d_mem_lsu.sv
// tb_d_mem_lsu: scoreboard bench for d_mem_lsu with a byte-array memory model.
module tb_d_mem_lsu;

    localparam int MEM_SIZE = 1024;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic        mem_r, mem_w;
    logic [31:0] mem_addr, mem_w_data, mem_r_data;
    logic [3:0]  mem_w_strb;

    logic [7:0]  mem [0:MEM_SIZE-1];

    int n_pass = 0;
    int n_total = 0;
    logic [31:0] last_rdata;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          lat;
    } exp_t;

    typedef struct {
        logic        accepted;
        logic        acc_r, acc_w;
        logic [31:0] acc_addr, acc_wdata;
        logic [3:0]  acc_strb;
        logic        any_mem, overlap;
        int          resp_count, lat;
        logic        err;
        logic [31:0] rdata;
    } obs_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    d_mem_lsu #(.ADDR_W(32), .MEM_SIZE(MEM_SIZE)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .Mem_r(mem_r), .Mem_w(mem_w), .Mem_Addr(mem_addr),
        .Mem_W_Data(mem_w_data), .Mem_W_Strb(mem_w_strb), .Mem_R_Data(mem_r_data)
    );

    // Memory write port: lane k goes to Mem_Addr+k under its strobe.
    always @(posedge clk) begin
        if (mem_w) begin
            for (int k = 0; k < 4; k++)
                if (mem_w_strb[k] && mem_addr < 32'(MEM_SIZE - k))
                    mem[mem_addr[9:0] + 10'(k)] <= mem_w_data[8*k +: 8];
        end
    end

    // Combinational read port: lane k = byte at Mem_Addr+k.
    always_comb begin
        mem_r_data = 32'h0;
        for (int k = 0; k < 4; k++)
            if (mem_addr < 32'(MEM_SIZE - k))
                mem_r_data[8*k +: 8] = mem[mem_addr[9:0] + 10'(k)];
    end

    // Drive one request and record what the DUT does over the next four cycles.
    task automatic run_req(input logic we, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           output obs_t o);
        int w;
        o = '{accepted: 1'b0, acc_r: 1'b0, acc_w: 1'b0, acc_addr: 32'h0,
              acc_wdata: 32'h0, acc_strb: 4'h0, any_mem: 1'b0, overlap: 1'b0,
              resp_count: 0, lat: 0, err: 1'b0, rdata: 32'h0};
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        w = 0;
        while (!req_ready && w < 10) begin @(negedge clk); w++; end
        if (!req_ready) begin req_valid = 1'b0; return; end
        @(posedge clk);
        o.accepted = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (c == 1) begin
                req_valid   = 1'b0;
                o.acc_r     = mem_r;
                o.acc_w     = mem_w;
                o.acc_addr  = mem_addr;
                o.acc_wdata = mem_w_data;
                o.acc_strb  = mem_w_strb;
            end
            if (mem_r | mem_w) o.any_mem = 1'b1;
            if (mem_r & mem_w) o.overlap = 1'b1;
            if (resp_valid) begin
                o.resp_count++;
                if (o.resp_count == 1) begin
                    o.lat = c; o.err = resp_err; o.rdata = resp_rdata;
                end
            end
        end
    endtask

    // Expected response for a request: loads update the held result, others keep it.
    task automatic push_exp(input logic we, input logic err, input logic [31:0] load_val);
        exp_t e;
        if (!we && !err) last_rdata = load_val;
        e.err = err; e.rdata = last_rdata; e.lat = err ? 1 : 2;
        sb.push_back(e);
    endtask

    task automatic test_reset;
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
        req_addr = 32'h0; req_wdata = 32'h0; last_rdata = 32'h0;
        #13;
        n_total++;
        if ({req_ready, resp_valid, resp_err, mem_r, mem_w} !== 5'b10000)
            $display("FAIL reset_ctrl got %b want 10000", {req_ready, resp_valid, resp_err, mem_r, mem_w});
        else n_pass++;
        n_total++;
        if ({resp_rdata, mem_addr, mem_w_data, mem_w_strb} !== 100'h0)
            $display("FAIL reset_data got rdata=%h addr=%h wd=%h strb=%b want zeros",
                     resp_rdata, mem_addr, mem_w_data, mem_w_strb);
        else n_pass++;
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_store_word;
        obs_t o; exp_t e;
        push_exp(1'b1, 1'b0, 32'h0);
        run_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, o);
        e = sb.pop_front();
        n_total++;
        if (!o.accepted) $display("FAIL sw_accept got 0 want 1"); else n_pass++;
        n_total++;
        if ({o.acc_w, o.acc_r, o.acc_strb} !== 6'b10_1111 || o.acc_addr !== 32'h10 || o.acc_wdata !== 32'hDEADBEEF)
            $display("FAIL sw_access got w=%b r=%b strb=%b addr=%h wd=%h want w=1 r=0 strb=1111 addr=10 wd=deadbeef",
                     o.acc_w, o.acc_r, o.acc_strb, o.acc_addr, o.acc_wdata);
        else n_pass++;
        n_total++;
        if (o.resp_count !== 1 || o.lat !== e.lat || o.err !== e.err)
            $display("FAIL sw_resp got cnt=%0d lat=%0d err=%b want cnt=1 lat=%0d err=%b",
                     o.resp_count, o.lat, o.err, e.lat, e.err);
        else n_pass++;
        push_exp(1'b0, 1'b0, 32'hDEADBEEF);
        run_req(1'b0, 3'b010, 32'h10, 32'h0, o);
        e = sb.pop_front();
        n_total++;
        if ({o.acc_r, o.acc_w} !== 2'b10 || o.acc_addr !== 32'h10)
            $display("FAIL lw_access got r=%b w=%b addr=%h want r=1 w=0 addr=10", o.acc_r, o.acc_w, o.acc_addr);
        else n_pass++;
        n_total++;
        if (o.resp_count !== 1 || o.lat !== e.lat || o.err !== e.err || o.rdata !== e.rdata)
            $display("FAIL lw_resp got cnt=%0d lat=%0d err=%b rdata=%h want lat=%0d err=%b rdata=%h",
                     o.resp_count, o.lat, o.err, o.rdata, e.lat, e.err, e.rdata);
        else n_pass++;
    endtask

    task automatic test_load_ext;
        logic [2:0]  f3  [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
        logic [31:0] ad  [4] = '{32'h13, 32'h13, 32'h12, 32'h12};
        logic [31:0] val [4] = '{32'hFFFFFFDE, 32'h000000DE, 32'hFFFFDEAD, 32'h0000DEAD};
        obs_t o; exp_t e;
        for (int i = 0; i < 4; i++) begin
            push_exp(1'b0, 1'b0, val[i]);
            run_req(1'b0, f3[i], ad[i], 32'h0, o);
            e = sb.pop_front();
            n_total++;
            if (o.resp_count !== 1 || o.lat !== e.lat || o.err !== e.err || o.rdata !== e.rdata || o.overlap)
                $display("FAIL load_ext[%0d] got cnt=%0d lat=%0d err=%b rdata=%h ovl=%b want lat=%0d err=%b rdata=%h",
                         i, o.resp_count, o.lat, o.err, o.rdata, o.overlap, e.lat, e.err, e.rdata);
            else n_pass++;
        end
    endtask

    task automatic test_sub_stores;
        obs_t o; exp_t e;
        logic [31:0] want_sh;
        push_exp(1'b1, 1'b0, 32'h0);
        run_req(1'b1, 3'b000, 32'h11, 32'h12345655, o);
        e = sb.pop_front();
        n_total++;
        if (o.acc_strb !== 4'b0001 || o.acc_addr !== 32'h11 || o.err !== e.err || o.rdata !== e.rdata)
            $display("FAIL sb_access got strb=%b addr=%h err=%b rdata=%h want strb=0001 addr=11 err=%b rdata=%h",
                     o.acc_strb, o.acc_addr, o.err, o.rdata, e.err, e.rdata);
        else n_pass++;
        push_exp(1'b0, 1'b0, 32'hDEAD55EF);
        run_req(1'b0, 3'b010, 32'h10, 32'h0, o);
        e = sb.pop_front();
        n_total++;
        if (o.rdata !== e.rdata) $display("FAIL sb_readback got %h want %h", o.rdata, e.rdata);
        else n_pass++;
        // Restore the word, then a halfword store at an odd address.
        push_exp(1'b1, 1'b0, 32'h0);
        run_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, o);
        e = sb.pop_front();
`ifdef LSU_MISALIGN_TRAP_EN
        push_exp(1'b1, 1'b1, 32'h0);
        want_sh = 32'hDEADBEEF;
`else
        push_exp(1'b1, 1'b0, 32'h0);
        want_sh = 32'hDE5678EF;
`endif
        run_req(1'b1, 3'b001, 32'h11, 32'hAAAA5678, o);
        e = sb.pop_front();
        n_total++;
        if (o.err !== e.err || o.lat !== e.lat || o.resp_count !== 1)
            $display("FAIL sh_resp got err=%b lat=%0d cnt=%0d want err=%b lat=%0d",
                     o.err, o.lat, o.resp_count, e.err, e.lat);
        else n_pass++;
        n_total++;
        if (e.err ? o.any_mem !== 1'b0 : o.acc_strb !== 4'b0011)
            $display("FAIL sh_access got mem=%b strb=%b want %s", o.any_mem, o.acc_strb,
                     e.err ? "no access" : "strb=0011");
        else n_pass++;
        push_exp(1'b0, 1'b0, want_sh);
        run_req(1'b0, 3'b010, 32'h10, 32'h0, o);
        e = sb.pop_front();
        n_total++;
        if (o.rdata !== e.rdata) $display("FAIL sh_readback got %h want %h", o.rdata, e.rdata);
        else n_pass++;
    endtask

    task automatic test_errors;
        logic        we [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic [2:0]  f3 [4] = '{3'b011, 3'b010, 3'b100, 3'b000};
        logic [31:0] ad [4] = '{32'h20, 32'(MEM_SIZE - 2), 32'h20, 32'hFFFFFFFF};
        obs_t o; exp_t e;
        for (int i = 0; i < 4; i++) begin
            push_exp(we[i], 1'b1, 32'h0);
            run_req(we[i], f3[i], ad[i], 32'h5A5A5A5A, o);
            e = sb.pop_front();
            n_total++;
            if (o.resp_count !== 1 || o.lat !== e.lat || o.err !== e.err || o.rdata !== e.rdata || o.any_mem)
                $display("FAIL err[%0d] got cnt=%0d lat=%0d err=%b rdata=%h mem=%b want lat=%0d err=1 rdata=%h mem=0",
                         i, o.resp_count, o.lat, o.err, o.rdata, o.any_mem, e.lat, e.rdata);
            else n_pass++;
        end
        // Last in-range word is still accepted.
        push_exp(1'b0, 1'b0, {mem[MEM_SIZE-1], mem[MEM_SIZE-2], mem[MEM_SIZE-3], mem[MEM_SIZE-4]});
        run_req(1'b0, 3'b010, 32'(MEM_SIZE - 4), 32'h0, o);
        e = sb.pop_front();
        n_total++;
        if (o.err !== 1'b0 || o.lat !== 2 || o.acc_r !== 1'b1)
            $display("FAIL top_word got err=%b lat=%0d r=%b want err=0 lat=2 r=1", o.err, o.lat, o.acc_r);
        else n_pass++;
    endtask

    task automatic test_reset_mid;
        obs_t o; exp_t e;
        int rv;
        push_exp(1'b1, 1'b0, 32'h0);
        run_req(1'b1, 3'b010, 32'h20, 32'hCAFEF00D, o);
        e = sb.pop_front();
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h20; req_wdata = 32'h11111111;
        @(posedge clk);
        #1;
        n_total++;
        if (mem_w !== 1'b1) $display("FAIL mid_access got mem_w=%b want 1", mem_w); else n_pass++;
        #1 rst_n = 1'b0; req_valid = 1'b0;
        #1;
        n_total++;
        if ({mem_w, mem_r, req_ready} !== 3'b001)
            $display("FAIL mid_reset got w=%b r=%b ready=%b want 0 0 1", mem_w, mem_r, req_ready);
        else n_pass++;
        @(negedge clk); rst_n = 1'b1;
        last_rdata = 32'h0;
        rv = 0;
        for (int c = 0; c < 4; c++) begin @(negedge clk); if (resp_valid) rv++; end
        n_total++;
        if (rv !== 0 || req_ready !== 1'b1)
            $display("FAIL mid_after got resp_pulses=%0d ready=%b want 0 1", rv, req_ready);
        else n_pass++;
        push_exp(1'b0, 1'b0, 32'hCAFEF00D);
        run_req(1'b0, 3'b010, 32'h20, 32'h0, o);
        e = sb.pop_front();
        n_total++;
        if (o.rdata !== e.rdata || o.err !== 1'b0)
            $display("FAIL mid_readback got %h err=%b want %h err=0", o.rdata, o.err, e.rdata);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_store_word();
        test_load_ext();
        test_sub_stores();
        test_errors();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
